// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

    // Detection modes selected by the ovl input.
    localparam logic MODE_NOVL = 1'b0;
    localparam logic MODE_OVL  = 1'b1;

    // Default pattern width and the matching progress width.
    localparam int PAT_W_DEFAULT = 4;
    localparam int PROG_W        = $clog2(PAT_W_DEFAULT + 1);

    // Widest pattern the prefix helper can examine (index width 5 bits).
    localparam int MAX_W = 32;

    // Longest k < pat_w such that k <= bits_since and the newest k bits of
    // hist (hist[k-1:0], hist[0] newest) equal the first k pattern bits
    // (pattern[pat_w-1 -: k], pattern[pat_w-1] received first).
    function automatic int prefix_len(input logic [MAX_W-1:0] hist,
                                      input logic [MAX_W-1:0] pattern,
                                      input int               pat_w,
                                      input int               bits_since);
        int   best;
        int   idx;
        logic ok;
        best = 0;
        for (int k = 1; k < MAX_W; k++) begin
            if (k < pat_w && k <= bits_since) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_W; i++) begin
                    if (i < k) begin
                        idx = pat_w - k + i;
                        if (hist[i] != pattern[idx[4:0]]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_n_sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: increment on inc unless already at the maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detector_n.sv
// Serial pattern detector with overlap modes, qualifier, abort, progress
// indicator and a saturating match counter.
module seq_detector_n
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       I,
    input  logic                       en,
    input  logic                       S,
    input  logic                       ovl,
    output logic                       B1,
    output logic                       B2,
    output logic [$clog2(PAT_W+1)-1:0] progress,
    output logic [CNT_W-1:0]           match_count
);

    localparam int PW = $clog2(PAT_W + 1);

    // hist: last PAT_W accepted bits, newest at bit 0.
    // bits: accepted bits since the last restart, saturating at PAT_W.
    logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
    logic [PW-1:0]    bits_q, bits_d, bits_inc;
    logic [PW-1:0]    prog_q, prog_d;
    logic             b1_q, b1_d;
    logic             b2_q, b2_d;
    logic             match;

    // Next-state for history, bit count, progress and the match pulse.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], I};
        bits_inc   = (bits_q == PW'(PAT_W)) ? bits_q : bits_q + PW'(1);
        hist_d     = hist_q;
        bits_d     = bits_q;
        prog_d     = prog_q;
        b1_d       = 1'b0;
        b2_d       = b2_q;
        match      = 1'b0;
        if (S) begin
            // Restart the window; a bit offered in this cycle is dropped.
            bits_d = '0;
            prog_d = '0;
            b2_d   = 1'b0;
        end else if (en) begin
            match  = (hist_shift == PATTERN) && (bits_inc == PW'(PAT_W));
            hist_d = hist_shift;
            if (match && (ovl == MODE_NOVL)) begin
                // Non-overlapping: the next match needs PAT_W fresh bits.
                bits_d = '0;
                prog_d = '0;
            end else begin
                bits_d = bits_inc;
                prog_d = PW'(prefix_len(MAX_W'(hist_shift), MAX_W'(PATTERN),
                                        PAT_W, int'(bits_inc)));
            end
            b1_d = match;
            b2_d = (prog_d != '0);
        end
    end

    // Detector state and registered outputs, synchronous reset first.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            bits_q <= '0;
            prog_q <= '0;
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            bits_q <= bits_d;
            prog_q <= prog_d;
            b1_q   <= b1_d;
            b2_q   <= b2_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .q     (match_count)
    );

    assign B1       = b1_q;
    assign B2       = b2_q;
    assign progress = prog_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed testbench for seq_detector_n: default instance plus a CNT_W=2
// instance driven by the same inputs for counter saturation.
module tb_seq_detector_n;

    logic       clk;
    logic       reset;
    logic       i_bit;
    logic       en;
    logic       s;
    logic       ovl;
    logic       b1, b2;
    logic [2:0] progress;
    logic [7:0] match_count;
    logic       b1_s, b2_s;
    logic [2:0] prog_s;
    logic [1:0] cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .I(i_bit), .en(en), .S(s), .ovl(ovl),
        .B1(b1), .B2(b2), .progress(progress), .match_count(match_count)
    );

    seq_detector_n #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .I(i_bit), .en(en), .S(s), .ovl(ovl),
        .B1(b1_s), .B2(b2_s), .progress(prog_s), .match_count(cnt_s)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, outputs are sampled
    // 1 time unit after the rising edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; s = 1'b0; i_bit = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        i_bit = b; en = 1'b1; s = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic b);
        @(negedge clk);
        i_bit = b; en = 1'b0; s = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic abort_cycle(input logic b);
        @(negedge clk);
        i_bit = b; en = 1'b1; s = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({b1, b2, progress, match_count} !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_state: got b1=%0b b2=%0b prog=%0d cnt=%0d expected all 0",
                     b1, b2, progress, match_count);
        end
    endtask

    task automatic test_overlap();
        int stim[7]   = '{1, 0, 1, 1, 0, 1, 1};
        int e_b1[7]   = '{0, 0, 0, 1, 0, 0, 1};
        int e_prog[7] = '{1, 2, 3, 1, 2, 3, 1};
        int e_cnt[7]  = '{0, 0, 0, 1, 1, 1, 2};
        do_reset();
        ovl = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(stim[k][0]);
            n_checks++;
            if (b1 !== e_b1[k][0] || progress !== 3'(e_prog[k]) ||
                b2 !== (e_prog[k] != 0) || match_count !== 8'(e_cnt[k])) begin
                n_errors++;
                $display("FAIL overlap step %0d: got b1=%0b b2=%0b prog=%0d cnt=%0d expected b1=%0d prog=%0d cnt=%0d",
                         k + 1, b1, b2, progress, match_count, e_b1[k], e_prog[k], e_cnt[k]);
            end
        end
    endtask

    task automatic test_non_overlap();
        int stim[7]   = '{1, 0, 1, 1, 0, 1, 1};
        int e_b1[7]   = '{0, 0, 0, 1, 0, 0, 0};
        int e_prog[7] = '{1, 2, 3, 0, 0, 1, 1};
        int e_cnt[7]  = '{0, 0, 0, 1, 1, 1, 1};
        do_reset();
        ovl = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(stim[k][0]);
            n_checks++;
            if (b1 !== e_b1[k][0] || progress !== 3'(e_prog[k]) ||
                b2 !== (e_prog[k] != 0) || match_count !== 8'(e_cnt[k])) begin
                n_errors++;
                $display("FAIL non_overlap step %0d: got b1=%0b b2=%0b prog=%0d cnt=%0d expected b1=%0d prog=%0d cnt=%0d",
                         k + 1, b1, b2, progress, match_count, e_b1[k], e_prog[k], e_cnt[k]);
            end
        end
    endtask

    task automatic test_qualifier_gaps();
        do_reset();
        ovl = 1'b1;
        step(1'b1);
        step(1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(k[0] ? 1'b0 : 1'b1);
            n_checks++;
            if (progress !== 3'd2 || b2 !== 1'b1 || b1 !== 1'b0 || match_count !== 8'd0) begin
                n_errors++;
                $display("FAIL gap_hold cycle %0d: got prog=%0d b2=%0b b1=%0b cnt=%0d expected prog=2 b2=1 b1=0 cnt=0",
                         k, progress, b2, b1, match_count);
            end
        end
        step(1'b1);
        n_checks++;
        if (progress !== 3'd3 || b1 !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_third_bit: got prog=%0d b1=%0b expected prog=3 b1=0", progress, b1);
        end
        step(1'b1);
        n_checks++;
        if (b1 !== 1'b1 || match_count !== 8'd1 || progress !== 3'd1) begin
            n_errors++;
            $display("FAIL gap_match: got b1=%0b cnt=%0d prog=%0d expected b1=1 cnt=1 prog=1",
                     b1, match_count, progress);
        end
        idle(1'b1);
        n_checks++;
        if (b1 !== 1'b0 || match_count !== 8'd1 || progress !== 3'd1) begin
            n_errors++;
            $display("FAIL gap_b1_drop: got b1=%0b cnt=%0d prog=%0d expected b1=0 cnt=1 prog=1",
                     b1, match_count, progress);
        end
    endtask

    task automatic test_abort();
        int stim[4]   = '{1, 0, 1, 1};
        int e_b1[4]   = '{0, 0, 0, 1};
        int e_prog[4] = '{1, 2, 3, 1};
        do_reset();
        ovl = 1'b1;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        abort_cycle(1'b1);
        n_checks++;
        if (progress !== 3'd0 || b2 !== 1'b0 || b1 !== 1'b0 || match_count !== 8'd0) begin
            n_errors++;
            $display("FAIL abort_cycle: got prog=%0d b2=%0b b1=%0b cnt=%0d expected 0 0 0 0",
                     progress, b2, b1, match_count);
        end
        for (int k = 0; k < 4; k++) begin
            step(stim[k][0]);
            n_checks++;
            if (b1 !== e_b1[k][0] || progress !== 3'(e_prog[k]) ||
                match_count !== 8'(e_b1[k])) begin
                n_errors++;
                $display("FAIL abort_refill step %0d: got b1=%0b prog=%0d cnt=%0d expected b1=%0d prog=%0d cnt=%0d",
                         k + 1, b1, progress, match_count, e_b1[k], e_prog[k], e_b1[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int stim[16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        int e_cnt[16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
        int pulses;
        logic exp_b1;
        pulses = 0;
        do_reset();
        ovl = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(stim[k][0]);
            exp_b1 = (k == 3) || (k == 6) || (k == 9) || (k == 12) || (k == 15);
            if (b1_s === 1'b1) pulses++;
            n_checks++;
            if (b1_s !== exp_b1 || cnt_s !== 2'(e_cnt[k])) begin
                n_errors++;
                $display("FAIL saturation step %0d: got b1=%0b cnt=%0d expected b1=%0b cnt=%0d",
                         k + 1, b1_s, cnt_s, exp_b1, e_cnt[k]);
            end
        end
        n_checks++;
        if (pulses != 5 || match_count !== 8'd5) begin
            n_errors++;
            $display("FAIL saturation_totals: got pulses=%0d wide_cnt=%0d expected pulses=5 wide_cnt=5",
                     pulses, match_count);
        end
    endtask

    task automatic test_reset_mid();
        int stim[7]   = '{0, 1, 1, 1, 0, 1, 1};
        int e_b1[7]   = '{0, 0, 0, 0, 0, 0, 1};
        int e_prog[7] = '{0, 1, 1, 1, 2, 3, 1};
        do_reset();
        ovl = 1'b1;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        @(negedge clk);
        reset = 1'b1; en = 1'b1; i_bit = 1'b1; s = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (progress !== 3'd0 || b2 !== 1'b0 || b1 !== 1'b0 || match_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got prog=%0d b2=%0b b1=%0b cnt=%0d expected 0 0 0 0",
                     progress, b2, b1, match_count);
        end
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(stim[k][0]);
            n_checks++;
            if (b1 !== e_b1[k][0] || progress !== 3'(e_prog[k]) ||
                match_count !== 8'(e_b1[k])) begin
                n_errors++;
                $display("FAIL reset_mid_refill step %0d: got b1=%0b prog=%0d cnt=%0d expected b1=%0d prog=%0d cnt=%0d",
                         k + 1, b1, progress, match_count, e_b1[k], e_prog[k], e_b1[k]);
            end
        end
    endtask

    // Test sequence and final report.
    initial begin
        reset = 1'b1; i_bit = 1'b0; en = 1'b0; s = 1'b0; ovl = 1'b1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_qualifier_gaps();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
